bram_master: RTL and testbench
==============================

BRAM_MASTER -- requirements
Module: bram_master

Interface
REQ-001 SHALL have parameter ADDR_, default 8, RAM address width in bits.
REQ-002 SHALL have parameter DATA_, default 8, RAM data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port aclr_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, requester has a request pending.
REQ-006 SHALL have port req_ready, output, 1, the block accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, request is a write (1) or a read (0).
REQ-008 SHALL have port req_addr, input, ADDR_, request address.
REQ-009 SHALL have port req_wdata, input, DATA_, write data.
REQ-010 SHALL have port rsp_valid, output, 1, read response available.
REQ-011 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-012 SHALL have port rsp_rdata, output, DATA_, read response data.
REQ-013 SHALL have port ram_we, output, 1, write enable to the single-port RAM.
REQ-014 SHALL have port ram_addr, output, ADDR_, RAM address.
REQ-015 SHALL have port ram_din, output, DATA_, RAM write data.
REQ-016 SHALL have port ram_dout, input, DATA_, RAM read data, from a registered RAM output.
REQ-017 SHALL have port busy, output, 1, at least one read is in flight or buffered.

Function
REQ-018 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1; this is the handshake.
REQ-019 SHALL register ram_we, ram_addr and ram_din from the accepted request; they are driven during the cycle after acceptance (edge E0).
REQ-020 SHALL drive ram_we=0 in every cycle that follows an edge with no accepted write; ram_addr and ram_din hold their last values.
REQ-021 SHALL model the RAM as sampling ram_addr at E1 and presenting ram_dout after E2, which is 2 cycles of RAM read latency.
REQ-022 SHALL track read issues in a 3-stage valid shift register covering the issue register, RAM input register and RAM output register.
REQ-023 SHALL push ram_dout into a 4-entry response FIFO at E3 for each read; total accept-to-rsp_valid latency is 3 cycles when the FIFO is empty.
REQ-024 SHALL keep writes out of the shift register and the FIFO; writes produce no response.
REQ-025 SHALL compute credits as inflight_reads + fifo_count - (pop this cycle ? 1 : 0).
REQ-026 SHALL drive req_ready=1 iff credits < 4, combinationally; a write and a read SHALL use the same ready.
REQ-027 SHALL sustain one read per cycle back-to-back when rsp_ready=1 continuously.
REQ-028 SHALL drive rsp_valid = FIFO not empty and rsp_rdata = FIFO head; a pop occurs on rsp_valid & rsp_ready.
REQ-029 SHALL return responses strictly in request order.
REQ-030 SHALL, on a simultaneous push and pop, leave fifo_count unchanged; with an empty FIFO the pop is not allowed in the push cycle (no bypass).
REQ-031 SHALL treat the credit rule as making FIFO overflow impossible; a push into a full FIFO SHALL never occur.
REQ-032 SHALL let write-then-read to the same address on consecutive cycles return the new data, as the RAM reads new data on that port.
REQ-033 SHALL let FIFO pointers wrap modulo 4; fifo_count is 3 bits, range 0..4.
REQ-034 SHALL drive busy=1 iff inflight_reads != 0 or fifo_count != 0.
REQ-035 SHALL keep rsp_rdata stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-036 SHALL, while aclr_n=0, immediately force ram_we=0, ram_addr=0, ram_din=0, the valid shift register to 0, FIFO pointers and count to 0, rsp_valid=0, busy=0, req_ready=0.
REQ-037 SHALL discard all in-flight reads on reset mid-operation; no stale response appears after release.
REQ-038 SHALL drive req_ready=1 in the first cycle after aclr_n rises.

Verification
REQ-039 SHALL cover single write then read: write addr 0x12 data 0xA5, then read 0x12 -> rsp_valid 3 cycles after the read handshake, rsp_rdata=0xA5.
REQ-040 SHALL cover streaming reads with rsp_ready=1: 8 consecutive reads of addr 0..7 preloaded with 0x10..0x17 -> req_ready stays 1, responses 0x10..0x17 on 8 consecutive cycles.
REQ-041 SHALL cover backpressure with rsp_ready=0: 6 reads offered -> exactly 4 accepted, req_ready=0 afterwards, 4 in-order responses held; raising rsp_ready drains them and req_ready returns to 1.
REQ-042 SHALL cover writes under full credits: with credits=4, a write is offered -> req_ready=0, ram_we stays 0 until a pop frees a credit.
REQ-043 SHALL cover reset mid-operation: aclr_n pulsed low with 2 reads in flight -> all outputs 0 at once, no rsp_valid after release, busy=0.
REQ-044 SHALL cover back-to-back write/read: write 0x3C to addr 0x05 at cycle N, read 0x05 at N+1 -> rsp_rdata=0x3C.

Source files
------------

// File: rtl/bram_master.sv
// Request/response front end for a single-port RAM with 2-cycle registered read latency.
// Reads are tracked in a 3-stage valid pipe and returned in order through a 4-entry FIFO.
module bram_master #(
    parameter int unsigned ADDR_ = 8,
    parameter int unsigned DATA_ = 8
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADDR_-1:0] req_addr,
    input  logic [DATA_-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATA_-1:0] rsp_rdata,
    output logic             ram_we,
    output logic [ADDR_-1:0] ram_addr,
    output logic [DATA_-1:0] ram_din,
    input  logic [DATA_-1:0] ram_dout,
    output logic             busy
);

    localparam int unsigned Depth = 4;

    logic             ram_we_q, ram_we_d;
    logic [ADDR_-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_-1:0] ram_din_q, ram_din_d;
    logic [2:0]       vld_q, vld_d;
    logic [DATA_-1:0] fifo_q [Depth];
    logic [DATA_-1:0] fifo_d [Depth];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;

    logic       accept;
    logic       push;
    logic       pop;
    logic [1:0] inflight;
    logic [3:0] credits;

    // Credits count every read that will occupy a FIFO slot; a pop this cycle frees one early.
    always_comb begin
        inflight  = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};
        pop       = (count_q != 3'd0) && rsp_ready;
        push      = vld_q[2];
        credits   = {2'b00, inflight} + {1'b0, count_q} - {3'b000, pop};
        req_ready = aclr_n && (credits < 4'd4);
        accept    = req_valid && req_ready;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end

    always_comb begin
        ram_we_d   = accept && req_we;
        ram_addr_d = accept ? req_addr : ram_addr_q;
        ram_din_d  = accept ? req_wdata : ram_din_q;
        vld_d      = {vld_q[1:0], accept && !req_we};
        fifo_d     = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = ram_dout;
        end
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
    end

    always_comb begin
        ram_we    = ram_we_q;
        ram_addr  = ram_addr_q;
        ram_din   = ram_din_q;
        rsp_valid = (count_q != 3'd0);
        rsp_rdata = fifo_q[rd_ptr_q];
        busy      = (vld_q != 3'd0) || (count_q != 3'd0);
    end

endmodule

// File: tb/tb_bram_master.sv
// Self-checking bench for bram_master: registered-RAM model, shadow memory and in-order
// response scoreboard, table-driven request vectors plus hand-written corner sequences.
module tb_bram_master;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;

    always #5 clk = ~clk;

    bram_master #(
        .ADDR_(AW),
        .DATA_(DW)
    ) dut (
        .clk      (clk),
        .aclr_n   (aclr_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    // Single-port RAM, write-first, input register then output register.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd1;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        rd1      <= ram_we ? ram_din : mem[ram_addr];
        ram_dout <= rd1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [DW-1:0] shadow [256];
    logic [DW-1:0] sb [$];
    int            cyc = 0;
    int            pop_cnt = 0;
    int            first_pop = -1;
    int            last_pop = -1;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data = '0;

    // Monitor: samples between edges, predicts reads at handshake, checks data at pop.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!aclr_n) begin
                sb.delete();
                hold = 1'b0;
            end else begin
                if (hold && rsp_valid) check("rsp_hold", rsp_rdata, hold_data);
                if (req_valid && req_ready) begin
                    if (req_we) shadow[req_addr] = req_wdata;
                    else sb.push_back(shadow[req_addr]);
                end
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("stale_rsp", rsp_valid, 0);
                    end else if (rsp_ready) begin
                        check("rsp_data", rsp_rdata, sb.pop_front());
                        pop_cnt++;
                        if (first_pop < 0) first_pop = cyc;
                        last_pop = cyc;
                    end
                end
                hold      = rsp_valid && !rsp_ready;
                hold_data = rsp_rdata;
            end
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          rsp_rdy;
        logic          exp_ready;
    } vec_t;

    vec_t vecs [$];

    task automatic apply(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        rsp_ready = v.rsp_rdy;
        #1 check("req_ready", req_ready, v.exp_ready);
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((busy || sb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t >= 200), 0);
    endtask

    task automatic wait_rsp(input string name);
        int t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t >= 20), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge clk);
        aclr_n = 1'b1;
        #1 check("rel_req_ready", req_ready, 1);

        // Single write then read with latency measurement
        drive(1'b1, 8'h12, 8'hA5);
        drive(1'b0, 8'h12, 8'h00);
        #1;
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 8'h12);
        check("wr_ram_din", ram_din, 8'hA5);
        idle();
        #1 check("rd_ram_we", ram_we, 0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("read_latency", 32'(lat), 3);
        check("wr_rd_data", rsp_rdata, 8'hA5);
        drain("drain_wr_rd");

        // Preload 0..7 then stream 8 reads
        for (int i = 0; i < 8; i++) vecs.push_back('{1'b1, AW'(i), DW'(8'h10 + i), 1'b1, 1'b1});
        for (int i = 0; i < 8; i++) vecs.push_back('{1'b0, AW'(i), 8'h00, 1'b1, 1'b1});
        for (int i = 0; i < 8; i++) apply(vecs[i]);
        idle();
        drain("drain_preload");
        pop_cnt   = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int i = 8; i < 16; i++) apply(vecs[i]);
        idle();
        drain("drain_stream");
        check("stream_pops", 32'(pop_cnt), 8);
        check("stream_span", 32'(last_pop - first_pop), 7);

        // Backpressure: 6 reads offered, only 4 fit
        vecs.delete();
        for (int i = 0; i < 6; i++) vecs.push_back('{1'b0, AW'(i), 8'h00, 1'b0, i < 4});
        pop_cnt = 0;
        foreach (vecs[i]) apply(vecs[i]);
        idle();
        #1;
        check("bp_req_ready", req_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_head", rsp_rdata, 8'h10);
        check("bp_busy", busy, 1);
        repeat (3) @(negedge clk);
        #1 check("bp_head_held", rsp_rdata, 8'h10);

        // Write under full credits waits for a pop
        drive(1'b1, 8'h20, 8'h77);
        #1 check("full_wr_ready", req_ready, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("full_wr_ram_we", ram_we, 0);
            check("full_wr_ready_hold", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 check("credit_freed", req_ready, 1);
        idle();
        #1;
        check("late_wr_ram_we", ram_we, 1);
        check("late_wr_ram_addr", ram_addr, 8'h20);
        drain("drain_bp");
        check("bp_pops", 32'(pop_cnt), 4);
        check("bp_ready_back", req_ready, 1);
        check("bp_idle_busy", busy, 0);

        // Reset with 2 reads in flight
        drive(1'b0, 8'h03, 8'h00);
        drive(1'b0, 8'h04, 8'h00);
        idle();
        aclr_n = 1'b0;
        #1;
        check("mid_ram_we", ram_we, 0);
        check("mid_ram_addr", ram_addr, 0);
        check("mid_ram_din", ram_din, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_rsp_rdata", rsp_rdata, 0);
        check("mid_busy", busy, 0);
        check("mid_req_ready", req_ready, 0);
        repeat (2) @(negedge clk);
        aclr_n = 1'b1;
        #1;
        check("mid_rel_ready", req_ready, 1);
        check("mid_rel_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check("no_stale", rsp_valid, 0);
        end

        // Back-to-back write/read of the same address
        drive(1'b1, 8'h05, 8'h3C);
        drive(1'b0, 8'h05, 8'h00);
        idle();
        wait_rsp("b2b_timeout");
        check("b2b_data", rsp_rdata, 8'h3C);
        drain("drain_b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
